// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with 2-flop row synchroniser and press/release debounce.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned REPEAT_DLY   = 50000,
    parameter int unsigned REPEAT_PER   = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [1:0] StScan     = 2'd0;
    localparam logic [1:0] StDebounce = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;
    localparam logic [1:0] StRelease  = 2'd3;

    localparam int unsigned WaitW = $clog2(SCAN_DIV);
    localparam int unsigned DebW  = $clog2(DEBOUNCE_CNT);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic [1:0]       row_idx;
    logic [3:0]       enc_code;
    logic             rows_idle;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RepW   = $clog2(RepMax);
    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_first_q, rep_first_d;
`endif

    assign rows_idle = &row_sync_q;

    // Lowest-index low row wins when several rows are pressed on one column.
    always_comb begin
        if (!pat_q[0])      row_idx = 2'd0;
        else if (!pat_q[1]) row_idx = 2'd1;
        else if (!pat_q[2]) row_idx = 2'd2;
        else                row_idx = 2'd3;
    end

    always_comb begin
        unique case ({row_idx, col_q})
            4'b00_00: enc_code = 4'b0001;
            4'b00_01: enc_code = 4'b0010;
            4'b00_10: enc_code = 4'b0011;
            4'b00_11: enc_code = 4'b1010;
            4'b01_00: enc_code = 4'b0100;
            4'b01_01: enc_code = 4'b0101;
            4'b01_10: enc_code = 4'b0110;
            4'b01_11: enc_code = 4'b1011;
            4'b10_00: enc_code = 4'b0111;
            4'b10_01: enc_code = 4'b1000;
            4'b10_10: enc_code = 4'b1001;
            4'b10_11: enc_code = 4'b1100;
            4'b11_00: enc_code = 4'b1110;
            4'b11_01: enc_code = 4'b0000;
            4'b11_10: enc_code = 4'b1111;
            default:  enc_code = 4'b1101;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        wait_d      = wait_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            StScan: begin
                if (wait_q == WaitW'(SCAN_DIV - 1)) begin
                    wait_d = '0;
                    if (rows_idle) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        pat_d   = row_sync_q;
                        deb_d   = '0;
                        state_d = StDebounce;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDebounce: begin
                if (row_sync_q != pat_q) begin
                    state_d = StScan;
                    wait_d  = '0;
                end else if (deb_q == DebW'(DEBOUNCE_CNT - 1)) begin
                    state_d     = StHeld;
                    key_code_d  = enc_code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b0;
`endif
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            StHeld: begin
                if (rows_idle) begin
                    state_d = StRelease;
                    deb_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if ((!rep_first_q && rep_q == RepW'(REPEAT_DLY - 1)) ||
                        (rep_first_q && rep_q == RepW'(REPEAT_PER - 1))) begin
                        key_valid_d = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
            end
            StRelease: begin
                if (!rows_idle) begin
                    state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b0;
`endif
                end else if (deb_q == DebW'(DEBOUNCE_CNT - 1)) begin
                    state_d    = StScan;
                    col_d      = col_q + 2'd1;
                    wait_d     = '0;
                    key_held_d = 1'b0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            state_q     <= StScan;
            col_q       <= 2'd0;
            wait_q      <= '0;
            deb_q       <= '0;
            pat_q       <= 4'b1111;
            key_code_q  <= 4'b0000;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_in;
            row_sync_q  <= row_meta_q;
            state_q     <= state_d;
            col_q       <= col_d;
            wait_q      <= wait_d;
            deb_q       <= deb_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign col_out   = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives row_in, expected
// key codes are queued at press time and checked by an independent monitor on key_valid.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DC = 8;
    localparam int unsigned RD = 40;
    localparam int unsigned RP = 16;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HoldLo = 34;
    localparam int HoldHi = 44;
`else
    localparam int HoldLo = 40;
    localparam int HoldHi = 120;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;   // bit r*4+c = key at (row r, col c) is down

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [3:0]  exp_q[$];
    int          pulse_cyc[$];
    bit          allow_rep = 1'b0;
    logic [3:0]  rep_code = 4'b0000;

    keypad_scanner #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DC),
        .REPEAT_DLY  (RD),
        .REPEAT_PER  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low if any pressed key on it sits on a driven-low column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    function automatic logic [3:0] code_of(input int r, input int c);
        if (r < 3 && c < 3) return 4'(r * 3 + c + 1);
        if (c == 3) return 4'(10 + r);
        if (c == 0) return 4'd14;
        if (c == 1) return 4'd0;
        return 4'd15;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press a set of keys sharing one column, hold, release, then confirm the event drained.
    task automatic press_event(input logic [15:0] keys, input int hold, input int gap);
        int lo_r = 4;
        int col  = 0;
        for (int r = 3; r >= 0; r--)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c]) begin
                    lo_r = r;
                    col  = c;
                end
        exp_q.push_back(code_of(lo_r, col));
        pressed = keys;
        tick(hold);
        chk("held_during_press", {3'b0, key_held}, 4'd1);
        pressed = '0;
        tick(gap);
        chk("held_after_release", {3'b0, key_held}, 4'd0);
        chk_int("pending_after_release", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk_int("col_onehot_low", $countones(~col_out), 1);
            if (key_valid) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    chk("key_code", key_code, exp_q.pop_front());
                    chk("held_at_accept", {3'b0, key_held}, 4'd1);
                end else if (allow_rep) begin
                    chk("repeat_code", key_code, rep_code);
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got code %h expected no pulse (cycle %0d)",
                             key_code, cyc);
                end
            end
        end
    end

    initial begin
        logic [15:0] keys;
        int r, c, r2, hold;
        pressed = '0;
        rst = 1'b1;
        tick(3);
        chk("rst_col_out", col_out, 4'b1110);
        chk("rst_key_code", key_code, 4'b0000);
        chk("rst_key_valid", {3'b0, key_valid}, 4'd0);
        chk("rst_key_held", {3'b0, key_held}, 4'd0);
        rst = 1'b0;
        tick(2);

        // '5' at (r1,c1)
        press_event(16'(1) << (1*4+1), HoldHi, 40);
        // '#' then 'D'
        press_event(16'(1) << (3*4+2), HoldHi, 40);
        press_event(16'(1) << (3*4+3), HoldHi, 40);

        // 'A' bouncing on (r0,c3), then settling low
        exp_q.push_back(code_of(0, 3));
        for (int i = 0; i < 10; i++) begin
            pressed[0*4+3] = ~pressed[0*4+3];
            tick(3);
        end
        chk_int("no_pulse_while_bouncing", exp_q.size(), 1);
        pressed[0*4+3] = 1'b1;
        tick(HoldLo + 6);
        chk("held_after_bounce", {3'b0, key_held}, 4'd1);
        pressed = '0;
        tick(40);
        chk_int("bounce_pending", exp_q.size(), 0);

        // '1' and '7' together on col0
        press_event((16'(1) << 0) | (16'(1) << 8), HoldHi, 40);

        // Randomised single and same-column double presses
        for (int n = 0; n < 20; n++) begin
            c = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 3));
            keys = 16'(1) << (r*4+c);
            if ($urandom_range(0, 2) == 0) begin
                r2 = int'($urandom_range(0, 3));
                keys = keys | (16'(1) << (r2*4+c));
            end
            hold = int'($urandom_range(HoldLo, HoldHi));
            press_event(keys, hold, int'($urandom_range(30, 60)));
        end

        // Reset four cycles into debounce of a col0 key
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        pressed = 16'(1) << (2*4+0);
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_col_out", col_out, 4'b1110);
        chk("mid_rst_key_code", key_code, 4'b0000);
        chk("mid_rst_key_valid", {3'b0, key_valid}, 4'd0);
        chk("mid_rst_key_held", {3'b0, key_held}, 4'd0);
        pressed = '0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("restart_col0", col_out, 4'b1110);
        tick(3);
        chk("restart_col1", col_out, 4'b1101);
        tick(20);

`ifdef KEYPAD_AUTOREPEAT_EN
        begin
            int rel_cyc;
            pulse_cyc.delete();
            allow_rep = 1'b1;
            rep_code  = code_of(2, 3);
            exp_q.push_back(code_of(2, 3));
            pressed = 16'(1) << (2*4+3);
            tick(120);
            rel_cyc = cyc;
            pressed = '0;
            tick(40);
            allow_rep = 1'b0;
            chk_int("repeat_count_ge5", int'(pulse_cyc.size() >= 5), 1);
            if (pulse_cyc.size() >= 2)
                chk_int("repeat_first_gap", pulse_cyc[1] - pulse_cyc[0], int'(RD));
            for (int i = 2; i < pulse_cyc.size(); i++)
                chk_int("repeat_period", pulse_cyc[i] - pulse_cyc[i-1], int'(RP));
            if (pulse_cyc.size() > 0)
                chk_int("no_repeat_after_release", int'(pulse_cyc[pulse_cyc.size()-1] <= rel_cyc + 3), 1);
        end
`endif

        tick(50);
        chk_int("final_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
